// File: rtl/uart_cmd_frame_decoder_pkg.sv
// Shared constants, state encoding and byte-lookup helpers for the UART command frame decoder.
package uart_cmd_pkg;

  localparam int FRAME_LEN   = 20;
  localparam int PAYLOAD_LEN = 10;

  localparam logic [7:0] HDR0  = 8'hAA;
  localparam logic [7:0] HDR1  = 8'h55;
  localparam logic [7:0] HDR2  = 8'hA5;
  localparam logic [7:0] HDR3  = 8'h5A;
  localparam logic [7:0] TAIL0 = 8'hCC;
  localparam logic [7:0] TAIL1 = 8'h33;
  localparam logic [7:0] TAIL2 = 8'hC3;
  localparam logic [7:0] TAIL3 = 8'h3C;

  localparam logic [2:0] ERR_SUM     = 3'd1;
  localparam logic [2:0] ERR_CH      = 3'd2;
  localparam logic [2:0] ERR_TAIL    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_PARAM   = 3'd5;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CH,
    ST_PAYLOAD,
    ST_SUM,
    ST_TAIL
  } state_e;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return HDR0;
      2'd1:    return HDR1;
      2'd2:    return HDR2;
      default: return HDR3;
    endcase
  endfunction

  function automatic logic [7:0] tail_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return TAIL0;
      2'd1:    return TAIL1;
      2'd2:    return TAIL2;
      default: return TAIL3;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_frame_decoder_if.sv
// Byte-stream input and command/error output bundle of the frame decoder.
interface uart_cmd_frame_decoder_if;
  logic        i_rx_en;
  logic [7:0]  i_rx_data;
  logic        o_cmd_valid;
  logic [7:0]  o_cmd_ch;
  logic [31:0] o_period;
  logic [31:0] o_high;
  logic [15:0] o_num;
  logic        o_err_valid;
  logic [2:0]  o_err_code;

  modport slave (
    input  i_rx_en, i_rx_data,
    output o_cmd_valid, o_cmd_ch, o_period, o_high, o_num, o_err_valid, o_err_code
  );

  modport master (
    output i_rx_en, i_rx_data,
    input  o_cmd_valid, o_cmd_ch, o_period, o_high, o_num, o_err_valid, o_err_code
  );
endinterface

// File: rtl/uart_cmd_frame_decoder_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear, pulses once on expiry.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear in the same cycle suppresses expiry so an arriving byte always wins.
  assign o_expire = i_en && !i_clr && (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_expire) cnt_d = '0;
    else if (i_en)         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_frame_decoder.sv
// Parses AA55A55A-framed PWM/beep commands from a UART byte stream into registered
// command or error strobes.
module uart_cmd_frame_decoder
  import uart_cmd_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  uart_cmd_frame_decoder_if.slave  bus
);

  localparam logic [8:0] CH_LIM = 9'(CH_NUM);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  ch_q, ch_d;
  logic [7:0]  acc_q, acc_d;
  logic [79:0] shadow_q, shadow_d;
  logic        sum_ok_q, sum_ok_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_ch_q, cmd_ch_d;
  logic [31:0] period_q, period_d;
  logic [31:0] high_q, high_d;
  logic [15:0] num_q, num_d;
  logic        err_valid_q, err_valid_d;
  logic [2:0]  err_code_q, err_code_d;

  logic [7:0]  rx;
  logic [31:0] sh_period, sh_high;
  logic [15:0] sh_num;
  logic        ch_bad, param_bad, tmo_en, tmo_expire;

  assign rx        = bus.i_rx_data;
  // Payload is shifted in MSB-first as one 80-bit word: period, high, num.
  assign sh_period = shadow_q[79:48];
  assign sh_high   = shadow_q[47:16];
  assign sh_num    = shadow_q[15:0];
  assign ch_bad    = {1'b0, ch_q} >= CH_LIM;
  assign param_bad = (sh_period == 32'd0) || (sh_high > sh_period);
  assign tmo_en    = !((state_q == ST_HUNT) && (idx_q == 4'd0));

  uart_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_tmo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (bus.i_rx_en),
    .i_en     (tmo_en),
    .o_expire (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    shadow_d    = shadow_q;
    sum_ok_d    = sum_ok_q;
    cmd_valid_d = 1'b0;
    cmd_ch_d    = cmd_ch_q;
    period_d    = period_q;
    high_d      = high_q;
    num_d       = num_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;

    if (bus.i_rx_en) begin
      unique case (state_q)
        ST_HUNT: begin
          if (rx == hdr_byte(idx_q[1:0])) begin
            if (idx_q == 4'd3) begin
              state_d = ST_CH;
              idx_d   = 4'd0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            idx_d = (rx == HDR0) ? 4'd1 : 4'd0;
          end
        end
        ST_CH: begin
          ch_d    = rx;
          acc_d   = rx;
          state_d = ST_PAYLOAD;
          idx_d   = 4'd0;
        end
        ST_PAYLOAD: begin
          shadow_d = {shadow_q[71:0], rx};
          acc_d    = acc_q + rx;
          if (idx_q == 4'(PAYLOAD_LEN - 1)) begin
            state_d = ST_SUM;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        ST_SUM: begin
          sum_ok_d = (rx == acc_q);
          state_d  = ST_TAIL;
          idx_d    = 4'd0;
        end
        ST_TAIL: begin
          if (rx != tail_byte(idx_q[1:0])) begin
            // The bad tail byte doubles as a possible header start.
            err_valid_d = 1'b1;
            err_code_d  = ERR_TAIL;
            state_d     = ST_HUNT;
            idx_d       = (rx == HDR0) ? 4'd1 : 4'd0;
          end else if (idx_q == 4'd3) begin
            state_d = ST_HUNT;
            idx_d   = 4'd0;
            if (!sum_ok_q) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_SUM;
            end else if (ch_bad) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_CH;
            end else if (param_bad) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_PARAM;
            end else begin
              cmd_valid_d = 1'b1;
              cmd_ch_d    = ch_q;
              period_d    = sh_period;
              high_d      = sh_high;
              num_d       = sh_num;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_HUNT;
          idx_d   = 4'd0;
        end
      endcase
    end else if (tmo_expire) begin
      err_valid_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = ST_HUNT;
      idx_d       = 4'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q     <= ST_HUNT;
      idx_q       <= 4'd0;
      ch_q        <= 8'd0;
      acc_q       <= 8'd0;
      shadow_q    <= 80'd0;
      sum_ok_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_ch_q    <= 8'd0;
      period_q    <= 32'd0;
      high_q      <= 32'd0;
      num_q       <= 16'd0;
      err_valid_q <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      shadow_q    <= shadow_d;
      sum_ok_q    <= sum_ok_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ch_q    <= cmd_ch_d;
      period_q    <= period_d;
      high_q      <= high_d;
      num_q       <= num_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.o_cmd_valid = cmd_valid_q;
  assign bus.o_cmd_ch    = cmd_ch_q;
  assign bus.o_period    = period_q;
  assign bus.o_high      = high_q;
  assign bus.o_num       = num_q;
  assign bus.o_err_valid = err_valid_q;
  assign bus.o_err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_frame_decoder.sv
// Directed bench for the UART command frame decoder with hand-computed frames and checksums.
module tb_uart_cmd_frame_decoder;

  localparam int TMO = 1000;

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cmd_cnt = 0;
  int   err_cnt = 0;
  logic [1:0] last_pulse;

  uart_cmd_frame_decoder_if bus ();

  uart_cmd_frame_decoder #(
    .CH_NUM      (4),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (16)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (bus.o_cmd_valid === 1'b1) cmd_cnt++;
    if (bus.o_err_valid === 1'b1) err_cnt++;
    if (bus.o_cmd_valid === 1'b1 && bus.o_err_valid === 1'b1) begin
      vectors++;
      miscompares++;
      $error("FAIL excl: cmd_valid and err_valid both high at %0t", $time);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge i_clk);
    bus.i_rx_en   = 1'b1;
    bus.i_rx_data = b;
    @(negedge i_clk);
    bus.i_rx_en = 1'b0;
    last_pulse  = {bus.o_cmd_valid, bus.o_err_valid};
    repeat (gap) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [31:0] per, input logic [31:0] hi,
                            input logic [15:0] num, input logic [7:0] sum, input logic [7:0] t2,
                            input int gap, input int nbytes);
    logic [7:0] fr [20];
    fr = '{8'hAA, 8'h55, 8'hA5, 8'h5A, ch,
           per[31:24], per[23:16], per[15:8], per[7:0],
           hi[31:24], hi[23:16], hi[15:8], hi[7:0],
           num[15:8], num[7:0], sum,
           8'hCC, 8'h33, t2, 8'h3C};
    for (int i = 0; i < nbytes; i++) send_byte(fr[i], gap);
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] ch, input logic [31:0] per,
                          input logic [31:0] hi, input logic [15:0] num);
    chk({tag, ".ch"}, 32'(bus.o_cmd_ch), 32'(ch));
    chk({tag, ".period"}, bus.o_period, per);
    chk({tag, ".high"}, bus.o_high, hi);
    chk({tag, ".num"}, 32'(bus.o_num), 32'(num));
  endtask

  task automatic chk_counts(input string tag, input int c0, input int e0, input int dc, input int de);
    chk({tag, ".ncmd"}, 32'(cmd_cnt - c0), 32'(dc));
    chk({tag, ".nerr"}, 32'(err_cnt - e0), 32'(de));
  endtask

  initial begin
    int c0, e0, hold_bad;
    i_rst_n       = 1'b1;
    bus.i_rx_en   = 1'b0;
    bus.i_rx_data = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("rst.cmd_valid", 32'(bus.o_cmd_valid), 0);
    chk("rst.err_valid", 32'(bus.o_err_valid), 0);
    chk("rst.err_code", 32'(bus.o_err_code), 0);
    chk_outs("rst", 8'd0, 32'd0, 32'd0, 16'd0);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);

    // ch 2, 1000/100/5 at a scaled UART byte spacing
    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd2, 32'd1000, 32'd100, 16'd5, 8'h56, 8'hC3, 860, 20);
    chk("f1.pulse", 32'(last_pulse), 32'b10);
    chk_counts("f1", c0, e0, 1, 0);
    chk_outs("f1", 8'd2, 32'h3E8, 32'h64, 16'd5);

    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd0, 32'd5000, 32'd1000, 16'd5, 8'h8B, 8'hC3, 10, 20);
    chk("f2.pulse", 32'(last_pulse), 32'b10);
    chk_counts("f2", c0, e0, 1, 0);
    chk_outs("f2", 8'd0, 32'h1388, 32'h3E8, 16'd5);
    hold_bad = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge i_clk);
      if (bus.o_cmd_ch !== 8'd0 || bus.o_period !== 32'h1388 || bus.o_high !== 32'h3E8 ||
          bus.o_num !== 16'd5 || bus.o_cmd_valid !== 1'b0 || bus.o_err_valid !== 1'b0)
        hold_bad++;
    end
    chk("f2.hold", 32'(hold_bad), 0);

    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd2, 32'd1000, 32'd100, 16'd5, 8'h57, 8'hC3, 10, 20);
    chk("sum.pulse", 32'(last_pulse), 32'b01);
    chk("sum.code", 32'(bus.o_err_code), 1);
    chk_counts("sum", c0, e0, 0, 1);
    chk_outs("sum", 8'd0, 32'h1388, 32'h3E8, 16'd5);

    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd4, 32'd1000, 32'd100, 16'd5, 8'h58, 8'hC3, 10, 20);
    chk("ch.code", 32'(bus.o_err_code), 2);
    chk_counts("ch", c0, e0, 0, 1);

    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd2, 32'd1000, 32'd1200, 16'd5, 8'hA6, 8'hC3, 10, 20);
    chk("hi.code", 32'(bus.o_err_code), 5);
    chk_counts("hi", c0, e0, 0, 1);

    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd0, 32'd0, 32'd0, 16'd1, 8'h01, 8'hC3, 10, 20);
    chk("per0.code", 32'(bus.o_err_code), 5);
    chk_counts("per0", c0, e0, 0, 1);
    chk_outs("per0", 8'd0, 32'h1388, 32'h3E8, 16'd5);

    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd2, 32'd1000, 32'd100, 16'd5, 8'h56, 8'h00, 10, 20);
    chk("tail.code", 32'(bus.o_err_code), 3);
    chk_counts("tail", c0, e0, 0, 1);
    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd2, 32'd1000, 32'd100, 16'd5, 8'h56, 8'hC3, 10, 20);
    chk_counts("tail.next", c0, e0, 1, 0);
    chk_outs("tail.next", 8'd2, 32'h3E8, 32'h64, 16'd5);

    c0 = cmd_cnt; e0 = err_cnt;
    send_byte(8'hAA, 1);
    send_frame(8'd0, 32'd5000, 32'd1000, 16'd5, 8'h8B, 8'hC3, 1, 20);
    chk("ovl.pulse", 32'(last_pulse), 32'b10);
    chk_counts("ovl", c0, e0, 1, 0);
    chk_outs("ovl", 8'd0, 32'h1388, 32'h3E8, 16'd5);

    // highest legal channel, high == period, zero pulse count
    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd3, 32'd1000, 32'd1000, 16'd0, 8'hD9, 8'hC3, 10, 20);
    chk_counts("edge", c0, e0, 1, 0);
    chk_outs("edge", 8'd3, 32'h3E8, 32'h3E8, 16'd0);

    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd2, 32'd1000, 32'd100, 16'd5, 8'h56, 8'hC3, 10, 8);
    repeat (TMO + 200) @(negedge i_clk);
    chk("tmo.code", 32'(bus.o_err_code), 4);
    chk_counts("tmo", c0, e0, 0, 1);
    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd2, 32'd1000, 32'd100, 16'd5, 8'h56, 8'hC3, 10, 20);
    chk_counts("tmo.next", c0, e0, 1, 0);

    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd0, 32'd5000, 32'd1000, 16'd5, 8'h8B, 8'hC3, 10, 10);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk_outs("mrst", 8'd0, 32'd0, 32'd0, 16'd0);
    chk("mrst.code", 32'(bus.o_err_code), 0);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    chk_counts("mrst", c0, e0, 0, 0);
    c0 = cmd_cnt; e0 = err_cnt;
    send_frame(8'd2, 32'd1000, 32'd100, 16'd5, 8'h56, 8'hC3, 10, 20);
    chk_counts("mrst.next", c0, e0, 1, 0);
    chk_outs("mrst.next", 8'd2, 32'h3E8, 32'h64, 16'd5);

    repeat (5) @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
